muldiv_unit: RTL and testbench

- Multi-cycle signed/unsigned 32x32 multiply and divide unit that owns the HI/LO register pair.
- Sits beside the single-cycle ALU in the execute stage; the ALU's MFHI/MFLO paths read `hi`/`lo` from here.
- The control decoder issues `start` for MULT/MULTU/DIV/DIVU and stalls the pipeline on `busy`.
- Shift-add multiply and restoring divide, one bit per cycle, fixed latency.

---
 rtl/muldiv_unit.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle 32x32 multiply/divide unit owning the HI/LO pair
//
// Shift-add multiply and restoring divide, one bit per cycle. Every operation
// has the same 33-cycle latency: 32 iterations plus one sign-fix cycle.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   start        request a new operation (ignored while busy)
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in1, in2     rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we MTHI / MTLO write enables (honoured only while not busy)
//   wdata        MTHI / MTLO data
//   busy         operation in progress, pipeline must stall
//   done         one-cycle pulse after HI/LO receive a result
//   div_by_zero  last divide had a zero divisor; cleared by the next start
//   hi, lo       HI / LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // Only the mul/div distinction survives past acceptance; signedness is
  // fully captured by the latched operand signs.
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] opnd;      // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;    // partial product high word / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier shifting out / dividend -> quotient
  logic [CW-1:0]    step_cnt;

  logic accept;
  logic last_step;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_step = (step_cnt == CW'(WIDTH - 1));
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_nx = S_FIX;
        end
      end
      S_FIX: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning at acceptance
  // ---------------------------------------------------------------------------
  logic             in_signed;
  logic             in1_neg;
  logic             in2_neg;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign in_signed = ~op[0];
  assign in1_neg   = in_signed & in1[WIDTH-1];
  assign in2_neg   = in_signed & in2[WIDTH-1];
  // The most negative value maps onto itself, which is its correct unsigned
  // magnitude.
  assign mag1      = in1_neg ? -in1 : in1;
  assign mag2      = in2_neg ? -in2 : in2;

  // ---------------------------------------------------------------------------
  // Per-iteration datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // Multiply: add multiplicand into the high word when the current multiplier
  // bit is set, then shift the whole {acc_hi, acc_lo} right by one.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // Divide: shift the next dividend bit into the remainder and trial-subtract.
  // The remainder is always below the divisor, so bit WIDTH of the difference
  // is set exactly when the subtraction borrows.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // ---------------------------------------------------------------------------
  // Sign correction
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               divisor_zero;

  assign prod         = {acc_hi, acc_lo};
  assign prod_fix     = (sign_a ^ sign_b) ? -prod : prod;
  assign quot_fix     = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
  assign rem_fix      = sign_a ? -acc_hi : acc_hi;
  assign divisor_zero = (opnd == '0);

  // ---------------------------------------------------------------------------
  // Datapath and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      step_cnt    <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      if (accept) begin
        is_div      <= op[1];
        sign_a      <= in1_neg;
        sign_b      <= in2_neg;
        opnd        <= op[1] ? mag2 : mag1;
        acc_hi      <= '0;
        acc_lo      <= op[1] ? mag1 : mag2;
        step_cnt    <= '0;
        div_by_zero <= 1'b0;
      end else if (state == S_RUN) begin
        step_cnt <= step_cnt + CW'(1);
        if (is_div) begin
          acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end else if (state == S_FIX) begin
        if (is_div) begin
          // A zero divisor never borrows, so the remainder path already
          // reconstructs the original dividend; only LO needs forcing.
          hi          <= rem_fix;
          lo          <= divisor_zero ? '1 : quot_fix;
          div_by_zero <= divisor_zero;
        end else begin
          hi          <= prod_fix[2*WIDTH-1:WIDTH];
          lo          <= prod_fix[WIDTH-1:0];
        end
      end

      // MTHI/MTLO only when not busy; FIX is a busy state, so these never
      // collide with a result write.
      if (!busy && hi_we) begin
        hi <= wdata;
      end
      if (!busy && lo_we) begin
        lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] last_hi;
  logic [31:0] last_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic, SV division truncates
  // toward zero and % follows the dividend's sign.
  task automatic ref_model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (f)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
          ez = 1'b1;
        end else begin
          if (f == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua) / longint'(ub);
            r = longint'(ua) % longint'(ub);
          end
          p  = {r[31:0], q[31:0]};
          eh = p[63:32];
          el = p[31:0];
        end
      end
    endcase
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge. mode 0: plain; 1: start/hi_we/lo_we while busy;
  // 2: MTLO in the same cycle the start is accepted. Returns at the negedge
  // following the result write, with the unit in DONE.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez,
                        input int mode);
    start = 1'b1;
    op    = f;
    in1   = a;
    in2   = b;
    if (mode == 2) begin
      lo_we = 1'b1;
      wdata = 32'h0000_CAFE;
    end
    @(negedge clock);
    start = 1'b0;
    lo_we = 1'b0;
    for (int i = 0; i < 33; i++) begin
      check("busy_run", busy, 1'b1);
      check("done_run", done, 1'b0);
      if (i == 0) begin
        check("dbz_cleared", div_by_zero, 1'b0);
        if (mode == 2) check("mtlo_with_start", lo, 32'h0000_CAFE);
      end
      if (mode == 1 && i == 5) begin
        start = 1'b1;
        op    = 2'b11;
        in1   = 32'($urandom);
        in2   = 32'($urandom);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
      end
      if (mode == 1 && i == 6) begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(negedge clock);
    end
    check("busy_done", busy, 1'b0);
    check("done_pulse", done, 1'b1);
    check("hi_result", hi, eh);
    check("lo_result", lo, el);
    check("dbz_result", div_by_zero, ez);
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic run_model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int mode);
    logic [31:0] eh;
    logic [31:0] el;
    logic        ez;
    ref_model(f, a, b, eh, el, ez);
    run_op(f, a, b, eh, el, ez, mode);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    in1   = '0;
    in2   = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_dbz", div_by_zero, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Directed vectors, issued back to back from DONE.
    run_op(2'b00, 32'h3AAA_1111, 32'h0000_2000, 32'h0000_0755, 32'h4222_2000, 1'b0, 0);
    run_op(2'b10, -32'sd101,      32'd3,        32'hFFFF_FFFE, 32'hFFFF_FFDF, 1'b0, 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(2'b10, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);

    // DONE -> IDLE, then MTLO while idle.
    @(negedge clock);
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clock);
    lo_we = 1'b0;
    check("mtlo_idle_lo", lo, 32'h0000_1234);
    check("mtlo_idle_hi", hi, last_hi);

    // Start and MTHI/MTLO while busy are ignored.
    run_model(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1);
    // MTLO in the accepting cycle, later overwritten by the result.
    run_model(2'b10, 32'h7654_3210, 32'h0000_0123, 2);

    // MTHI during DONE overrides the just-written result.
    hi_we = 1'b1;
    wdata = 32'h5555_AAAA;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi_done_hi", hi, 32'h5555_AAAA);
    check("mthi_done_lo", lo, last_lo);

    // Randomized operations, occasionally separated by idle cycles.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        check("gap_done", done, 1'b0);
      end
      run_model(2'($urandom_range(0, 3)), pick(), pick(), 0);
    end

    // Reset at cycle 10 of a MULT aborts it.
    start = 1'b1;
    op    = 2'b00;
    in1   = 32'h0001_0003;
    in2   = 32'h0002_0005;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_dbz", div_by_zero, 1'b0);
    for (int i = 0; i < 36; i++) begin
      @(negedge clock);
      check("no_done_after_abort", {busy, done}, 2'b00);
    end
    check("abort_lo_held", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
